// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the TDM demultiplexer and its slot counter.
package tdm_demux_pkg;

   localparam int unsigned N_CH_DEF  = 8;
   localparam int unsigned PAR_MAX_W = 64;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COLLECT = 2'd1,
      PARITY  = 2'd2
   } state_t;

   // Even parity of a vector of up to PAR_MAX_W bits; callers zero-extend.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter with clear and load-1; shared with the transmit sequencer.
module tdm_slot_ctr #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load1,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     cnt <= '0;
      else if (clr)   cnt <= '0;
      else if (load1) cnt <= W'(1);
      else if (inc)   cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/tdm_demux_8ch.sv
// Serial TDM to parallel word demultiplexer with valid/ready output.
// Define TDM_DEMUX_PARITY_EN to add an even-parity slot after the data slots.
module tdm_demux_8ch
   import tdm_demux_pkg::*;
#(
   parameter  int unsigned N_CH   = N_CH_DEF,
   localparam int unsigned SLOT_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   input  logic              din_valid,
   input  logic              frame_start,
   output logic [N_CH-1:0]   out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SLOT_W-1:0] cur_slot,
   output logic              overrun,
   output logic              sync_err,
   output logic              parity_err
);

   state_t            state, state_nxt;
   logic [N_CH-1:0]   shadow, shadow_nxt_c, word_c;
   logic              shadow_wr_c;
   logic [SLOT_W-1:0] shadow_idx_c;
   logic              ctr_clr_c, ctr_load1_c, ctr_inc_c;
   logic              commit_c, sync_err_c, parity_err_c;

   tdm_slot_ctr #(.W(SLOT_W)) u_slot_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ctr_clr_c),
      .load1 (ctr_load1_c),
      .inc   (ctr_inc_c),
      .cnt   (cur_slot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= HUNT;
         shadow <= '0;
      end else begin
         state  <= state_nxt;
         shadow <= shadow_nxt_c;
      end
   end

   // Beat decode: slot writes, counter control, word commit and error pulses.
   always_comb begin
      state_nxt    = state;
      shadow_wr_c  = 1'b0;
      shadow_idx_c = cur_slot;
      ctr_clr_c    = 1'b0;
      ctr_load1_c  = 1'b0;
      ctr_inc_c    = 1'b0;
      commit_c     = 1'b0;
      sync_err_c   = 1'b0;
      parity_err_c = 1'b0;

      if (din_valid) begin
         if (frame_start) begin
            sync_err_c   = (state != HUNT);
            shadow_wr_c  = 1'b1;
            shadow_idx_c = '0;
            ctr_load1_c  = 1'b1;
            state_nxt    = COLLECT;
         end else begin
            unique case (state)
               HUNT: state_nxt = HUNT;
               COLLECT: begin
                  shadow_wr_c = 1'b1;
                  if (cur_slot == SLOT_W'(N_CH - 1)) begin
`ifdef TDM_DEMUX_PARITY_EN
                     ctr_inc_c = 1'b1;
                     state_nxt = PARITY;
`else
                     commit_c  = 1'b1;
                     ctr_clr_c = 1'b1;
                     state_nxt = HUNT;
`endif
                  end else begin
                     ctr_inc_c = 1'b1;
                  end
               end
               PARITY: begin
                  ctr_clr_c = 1'b1;
                  state_nxt = HUNT;
`ifdef TDM_DEMUX_PARITY_EN
                  if (din == even_parity(PAR_MAX_W'(shadow))) commit_c     = 1'b1;
                  else                                        parity_err_c = 1'b1;
`endif
               end
               default: state_nxt = HUNT;
            endcase
         end
      end

      shadow_nxt_c = shadow;
      if (shadow_wr_c) shadow_nxt_c[shadow_idx_c] = din;
`ifdef TDM_DEMUX_PARITY_EN
      word_c = shadow;
`else
      word_c = shadow_nxt_c;
`endif
   end

   // Output word register, handshake and one-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
         sync_err   <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         overrun    <= 1'b0;
         sync_err   <= sync_err_c;
         parity_err <= parity_err_c;
         if (commit_c) begin
            if (out_valid && !out_ready) begin
               overrun <= 1'b1;
            end else begin
               out_data  <= word_c;
               out_valid <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
